// File: rtl/kernel_pkg.sv
// Shared definitions for the kernel-path packers: size derivation, config check, FSM states.
package kernel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int wide_f(input int group_nb, input int ker_width, input int depth_nb);
        return group_nb * ker_width * depth_nb;
    endfunction

    function automatic int beats_f(input int wide, input int str_width);
        return wide / str_width;
    endfunction

    // The wide word must split evenly into at least two narrow beats.
    function automatic bit wide_ok_f(input int wide, input int str_width);
        return (str_width > 0) && (wide % str_width == 0) && (wide / str_width >= 2);
    endfunction

endpackage

// File: rtl/kernel_pack_oreg.sv
// Single-entry output register with load/valid/ready; a load in the same cycle as a
// handshake keeps the entry valid with the new word.
module kernel_pack_oreg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         rdy_i,
    output logic         val_o,
    output logic [W-1:0] data_o
);

    logic         val_q, val_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        val_d  = val_q;
        data_d = data_q;
        if (load_i) begin
            val_d  = 1'b1;
            data_d = data_i;
        end else if (val_q && rdy_i) begin
            val_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= 1'b0;
            data_q <= '0;
        end else begin
            val_q  <= val_d;
            data_q <= data_d;
        end
    end

    assign val_o  = val_q;
    assign data_o = data_q;

endmodule

// File: rtl/kernel_pack.sv
// Narrow-to-wide kernel stream packer feeding the kernel memory write port.
// KERNEL_PACK_MSB_FIRST_EN places the first beat in the MSBs instead of the LSBs.
module kernel_pack
    import kernel_pkg::*;
#(
    parameter int GROUP_NB  = 4,
    parameter int KER_WIDTH = 16,
    parameter int DEPTH_NB  = 16,
    parameter int STR_WIDTH = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [CNT_WIDTH-1:0]                                cfg_words,
    input  logic                                                cfg_set,
    input  logic [STR_WIDTH-1:0]                                str_data,
    input  logic                                                str_val,
    output logic                                                str_rdy,
    output logic [wide_f(GROUP_NB, KER_WIDTH, DEPTH_NB)-1:0]    wr_data,
    output logic                                                wr_data_val,
    input  logic                                                wr_data_rdy,
    output logic                                                busy,
    output logic                                                done
);

    localparam int WIDE  = wide_f(GROUP_NB, KER_WIDTH, DEPTH_NB);
    localparam int BEATS = beats_f(WIDE, STR_WIDTH);
    localparam int BW    = $clog2(BEATS);

    if (!wide_ok_f(WIDE, STR_WIDTH)) begin : g_cfg_err
        $error("kernel_pack: WIDE must be a multiple of STR_WIDTH with at least 2 beats");
    end

    state_e                state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [CNT_WIDTH-1:0]  wcnt_q, wcnt_d;
    logic [WIDE-1:0]       pack_q, pack_d, word;
    logic                  done_q, done_d;
    logic [BW-1:0]         slot;
    logic                  last, accept, load;

`ifdef KERNEL_PACK_MSB_FIRST_EN
    assign slot = BW'(BEATS - 1) - beat_q;
`else
    assign slot = beat_q;
`endif

    assign last    = (beat_q == BW'(BEATS - 1));
    // Only the closing beat waits for the output register; earlier beats go into pack_q.
    assign str_rdy = (state_q == ST_FILL) && !(last && wr_data_val && !wr_data_rdy);
    assign accept  = str_val && str_rdy;

    always_comb begin
        word = pack_q;
        word[slot*STR_WIDTH +: STR_WIDTH] = str_data;
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wcnt_d  = wcnt_q;
        pack_d  = pack_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_set) begin
                    if (cfg_words != '0) begin
                        wcnt_d  = cfg_words;
                        beat_d  = '0;
                        state_d = ST_FILL;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (accept) begin
                    pack_d = word;
                    if (last) begin
                        load   = 1'b1;
                        beat_d = '0;
                        wcnt_d = wcnt_q - CNT_WIDTH'(1);
                        if (wcnt_q == CNT_WIDTH'(1)) state_d = ST_DRAIN;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (wr_data_val && wr_data_rdy) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            wcnt_q  <= '0;
            pack_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
            pack_q  <= pack_d;
            done_q  <= done_d;
        end
    end

    kernel_pack_oreg #(.W(WIDE)) u_oreg (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .data_i (word),
        .rdy_i  (wr_data_rdy),
        .val_o  (wr_data_val),
        .data_o (wr_data)
    );

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_kernel_pack.sv
// Self-checking bench for kernel_pack: directed scenarios plus randomized transfers
// against a beat-queue reference model.
module tb_kernel_pack;

    localparam int GN = 1, KW = 8, DN = 4, SW = 8, CW = 16;
    localparam int W  = GN * KW * DN;
    localparam int NB = W / SW;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cfg_words;
    logic          cfg_set;
    logic [SW-1:0] str_data;
    logic          str_val;
    logic          str_rdy;
    logic [W-1:0]  wr_data;
    logic          wr_data_val;
    logic          wr_data_rdy;
    logic          busy;
    logic          done;

    kernel_pack #(
        .GROUP_NB(GN), .KER_WIDTH(KW), .DEPTH_NB(DN), .STR_WIDTH(SW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_words(cfg_words), .cfg_set(cfg_set),
        .str_data(str_data), .str_val(str_val), .str_rdy(str_rdy),
        .wr_data(wr_data), .wr_data_val(wr_data_val), .wr_data_rdy(wr_data_rdy),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] expw(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
`ifdef KERNEL_PACK_MSB_FIRST_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    // Reference model: collect accepted beats, form words, compare at each write handshake.
    logic [7:0]   part[$];
    logic [W-1:0] exp_q[$];
    int           wcyc[$];
    int           words = 0, dones = 0, cyc = 0;
    logic         pv = 1'b0, pr = 1'b0;
    logic [W-1:0] pd = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            part.delete();
            exp_q.delete();
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_val", wr_data_val, 1'b1);
                chk("hold_data", wr_data, pd);
            end
            if (!busy) chk("rdy_idle", str_rdy, 1'b0);
            if (str_val && str_rdy) begin
                part.push_back(str_data);
                if (part.size() == NB) begin
                    exp_q.push_back(expw(part[0], part[1], part[2], part[3]));
                    part.delete();
                end
            end
            if (wr_data_val && wr_data_rdy) begin
                chk("word_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("word", wr_data, exp_q.pop_front());
                words++;
                wcyc.push_back(cyc);
            end
            if (done) dones++;
            pv = wr_data_val;
            pr = wr_data_rdy;
            pd = wr_data;
        end
    end

    bit rnd = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_rdy();
        if (rnd) wr_data_rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic start(input int n);
        cfg_words = CW'(n);
        cfg_set   = 1'b1;
        tick();
        cfg_set   = 1'b0;
        rand_rdy();
    endtask

    // Holds str_val high on return so back-to-back calls stream without bubbles.
    task automatic push(input logic [7:0] b, output int waits);
        bit acc;
        waits    = 0;
        str_val  = 1'b1;
        str_data = b;
        do begin
            @(posedge clk);
            acc = str_rdy;
            #1;
            rand_rdy();
            if (!acc) waits++;
        end while (!acc && waits < 200);
        chk("push_accept", acc, 1'b1);
    endtask

    task automatic wait_done();
        int n = 0;
        str_val = 1'b0;
        while (!done && n < 300) begin
            tick();
            rand_rdy();
            n++;
        end
        chk("done_seen", done, 1'b1);
        chk("busy_at_done", busy, 1'b0);
    endtask

    int w, wsum, w0, d0, n;
    logic [7:0] b[8];

    initial begin
        rst = 1'b1; cfg_words = '0; cfg_set = 1'b0; str_data = '0; str_val = 1'b0;
        wr_data_rdy = 1'b0;
        repeat (3) tick();
        chk("rst_str_rdy", str_rdy, 1'b0);
        chk("rst_val", wr_data_val, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_data", wr_data, '0);
        rst = 1'b0;
        tick();

        // 1: single word, latency and done timing
        wr_data_rdy = 1'b1;
        start(1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_rdy", str_rdy, 1'b1);
        push(8'h11, w); push(8'h22, w); push(8'h33, w);
        chk("t1_val_early", wr_data_val, 1'b0);
        push(8'h44, w);
        chk("t1_val", wr_data_val, 1'b1);
        chk("t1_data", wr_data, expw(8'h11, 8'h22, 8'h33, 8'h44));
        str_val = 1'b0;
        tick();
        chk("t1_done", done, 1'b1);
        chk("t1_busy_fall", busy, 1'b0);
        chk("t1_val_clr", wr_data_val, 1'b0);
        tick();
        chk("t1_done_pulse", done, 1'b0);

        // 2: streaming three words with no bubbles
        w0 = words; d0 = dones; wsum = 0;
        wcyc.delete();
        start(3);
        for (int i = 0; i < 12; i++) begin
            push(8'($urandom), w);
            wsum += w;
        end
        wait_done();
        tick();
        chk("t2_stalls", wsum, 0);
        chk("t2_words", words - w0, 3);
        chk("t2_dones", dones - d0, 1);
        if (wcyc.size() == 3) begin
            chk("t2_gap0", wcyc[1] - wcyc[0], 4);
            chk("t2_gap1", wcyc[2] - wcyc[1], 4);
        end else chk("t2_wcyc", wcyc.size(), 3);

        // 3: backpressure on the closing beat of the second word
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        wr_data_rdy = 1'b0;
        start(2);
        wsum = 0;
        for (int i = 0; i < 4; i++) begin push(b[i], w); wsum += w; end
        chk("t3_val1", wr_data_val, 1'b1);
        chk("t3_word1", wr_data, expw(b[0], b[1], b[2], b[3]));
        for (int i = 4; i < 7; i++) begin push(b[i], w); wsum += w; end
        chk("t3_stalls", wsum, 0);
        str_data = b[7];
        chk("t3_stall_rdy", str_rdy, 1'b0);
        repeat (3) tick();
        chk("t3_still_stalled", str_rdy, 1'b0);
        chk("t3_word1_held", wr_data, expw(b[0], b[1], b[2], b[3]));
        wr_data_rdy = 1'b1;
        push(b[7], w);
        chk("t3_release_waits", w, 0);
        chk("t3_val2", wr_data_val, 1'b1);
        chk("t3_word2", wr_data, expw(b[4], b[5], b[6], b[7]));
        wait_done();
        tick();

        // 4: zero-word config, then ignored cfg_set mid-transfer
        start(0);
        chk("t4_done0", done, 1'b1);
        chk("t4_busy0", busy, 1'b0);
        tick();
        chk("t4_done0_pulse", done, 1'b0);
        chk("t4_busy0_idle", busy, 1'b0);
        w0 = words; d0 = dones;
        start(2);
        push(8'($urandom), w); push(8'($urandom), w);
        str_val = 1'b0;
        cfg_words = CW'(5); cfg_set = 1'b1;
        tick();
        cfg_set = 1'b0;
        chk("t4_busy_mid", busy, 1'b1);
        for (int i = 0; i < 6; i++) push(8'($urandom), w);
        wait_done();
        tick();
        chk("t4_words", words - w0, 2);
        chk("t4_dones", dones - d0, 1);

        // 5: reset mid-word discards the partial word
        start(1);
        push(8'h5A, w); push(8'hC3, w);
        str_val = 1'b0;
        rst = 1'b1;
        tick();
        chk("t5_str_rdy", str_rdy, 1'b0);
        chk("t5_val", wr_data_val, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_data", wr_data, '0);
        rst = 1'b0;
        tick();
        start(1);
        push(8'hA1, w); push(8'hA2, w); push(8'hA3, w); push(8'hA4, w);
        chk("t5_word", wr_data, expw(8'hA1, 8'hA2, 8'hA3, 8'hA4));
        wait_done();
        tick();

        // Randomized transfers with random gaps and random backpressure
        rnd = 1'b1;
        for (int t = 0; t < 8; t++) begin
            n  = $urandom_range(1, 4);
            w0 = words;
            start(n);
            for (int i = 0; i < n * NB; i++) begin
                str_val = 1'b0;
                repeat ($urandom_range(0, 2)) begin tick(); rand_rdy(); end
                push(8'($urandom), w);
            end
            wait_done();
            tick();
            chk("rnd_words", words - w0, n);
        end
        rnd = 1'b0;
        wr_data_rdy = 1'b1;
        tick();
        chk("model_empty", exp_q.size(), 0);
        chk("model_no_partial", part.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
